gppcu_instr_issue_ctrl: RTL and testbench

- Instruction queue and issue sequencer in front of the GPPCU thread array.
- Host side pushes 32-bit instructions into an internal FIFO.
- Issue FSM pops them one at a time, presents each to the core for one cycle, and holds further issue while the core reports a multi-cycle operation (LMEM/GMEM access) in progress.
- Also provides flush, pause, an overflow flag and an idle indication for the host driver.

---
 rtl/gppcu_pkg.sv | 30 +++
 rtl/gppcu_sync_fifo.sv | 92 +++++++++
 rtl/gppcu_instr_issue_ctrl.sv | 149 ++++++++++++++
 tb/tb_gppcu_instr_issue_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gppcu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gppcu_pkg
// Description : Shared definitions for the GPPCU instruction issue path.
//               Holds the issue FSM state encoding, the default instruction
//               width and the opcode field position used by later decode.
// Revision    : 1.0 - initial release
// ============================================================================
package gppcu_pkg;

    // Issue FSM state encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = c_st_idle,
        ISSUE = c_st_issue,
        WAIT  = c_st_wait
    } issue_state_e;

    // Default instruction word width
    localparam int c_instr_w = 32;

    // Opcode field of an instruction word, reserved for future decode
    localparam int c_opcode_msb = 31;
    localparam int c_opcode_lsb = 26;

endpackage : gppcu_pkg
`default_nettype wire

// File: rtl/gppcu_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gppcu_sync_fifo
// Description : Single-clock instruction FIFO with occupancy count and a
//               registered "not full" indication.
//   clk_i    - clock, rising edge
//   rst_i    - asynchronous active-high reset
//   flush_i  - synchronous clear of pointers and count (beats push/pop)
//   push_i   - write request (ignored when full or flushing)
//   wdata_i  - write data
//   pop_i    - read request (ignored when empty or flushing)
//   rdata_o  - head of queue (combinational)
//   count_o  - occupancy
//   empty_o  - occupancy is zero
//   ready_o  - registered: occupancy below depth
// Revision    : 1.0 - initial release
// ============================================================================
module gppcu_sync_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic                  pop_i,
    output logic [DATA_W-1:0]     rdata_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  empty_o,
    output logic                  ready_o
);

    localparam int                c_entries = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_depth = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DATA_W-1:0]     mem_q [c_entries];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ready_q, ready_d;
    logic                  w_push;
    logic                  w_pop;

    // The registered ready is the full test, so a pop in the same cycle
    // never lets a push into a full queue.
    assign w_push = push_i && ready_q && !flush_i;
    assign w_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (w_push && !w_pop)      count_d = count_q + 1'b1;
            else if (!w_push && w_pop) count_d = count_q - 1'b1;
        end
        ready_d = (count_d < c_depth);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Storage carries no reset; entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign ready_o = ready_q;

endmodule : gppcu_sync_fifo
`default_nettype wire

// File: rtl/gppcu_instr_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gppcu_instr_issue_ctrl
// Description : Instruction queue and issue sequencer for the GPPCU thread
//               array. Host pushes words into a FIFO; the issue FSM pops
//               one at a time, strobes it to the core for one cycle and
//               waits while the core reports a multi-cycle operation.
//   iACLK / iRST                 - clock / async active-high reset
//   iINSTR_VALID, iINSTR         - host write strobe and word
//   oINSTR_READY, oQ_COUNT       - FIFO not full (registered), occupancy
//   iRUN, iFLUSH                 - issue enable, synchronous queue clear
//   oISSUE_VALID, oISSUE_INSTR   - one-cycle issue strobe and word
//   iCORE_BUSY                   - core executing multi-cycle instruction
//   oOVERFLOW, oIDLE             - sticky dropped-write flag, idle status
// Optional    : define GPPCU_ISSUE_STATS_EN to add oSTAT_ISSUED and
//               oSTAT_STALL counters.
// Revision    : 1.0 - initial release
// ============================================================================
module gppcu_instr_issue_ctrl
    import gppcu_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int INSTR_W    = c_instr_w
) (
    input  logic                 iACLK,
    input  logic                 iRST,
    input  logic                 iINSTR_VALID,
    input  logic [INSTR_W-1:0]   iINSTR,
    output logic                 oINSTR_READY,
    output logic [DEPTH_LOG2:0]  oQ_COUNT,
    input  logic                 iRUN,
    input  logic                 iFLUSH,
    output logic                 oISSUE_VALID,
    output logic [INSTR_W-1:0]   oISSUE_INSTR,
    input  logic                 iCORE_BUSY,
`ifdef GPPCU_ISSUE_STATS_EN
    output logic [31:0]          oSTAT_ISSUED,
    output logic [31:0]          oSTAT_STALL,
`endif
    output logic                 oOVERFLOW,
    output logic                 oIDLE
);

    issue_state_e        state_q, state_d;
    logic [INSTR_W-1:0]  issue_instr_q;
    logic                overflow_q;
    logic                w_pop;
    logic                w_empty;
    logic                w_ready;
    logic                w_can_issue;
    logic [INSTR_W-1:0]  w_head;

    gppcu_sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (INSTR_W)
    ) u_fifo (
        .clk_i   (iACLK),
        .rst_i   (iRST),
        .flush_i (iFLUSH),
        .push_i  (iINSTR_VALID),
        .wdata_i (iINSTR),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .count_o (oQ_COUNT),
        .empty_o (w_empty),
        .ready_o (w_ready)
    );

    // A flush suppresses any pop in its cycle.
    assign w_can_issue = iRUN && !w_empty && !iFLUSH;

    always_comb begin
        state_d = state_q;
        w_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_can_issue) begin
                    w_pop   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Busy is only looked at here; the core raises it the cycle
                // after the issue strobe.
                if (iCORE_BUSY) begin
                    state_d = WAIT;
                end else if (w_can_issue) begin
                    w_pop   = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iACLK or posedge iRST) begin
        if (iRST) begin
            state_q       <= IDLE;
            issue_instr_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            // The issued word is held until the next pop, even in IDLE.
            if (w_pop) issue_instr_q <= w_head;
            if (iFLUSH)
                overflow_q <= 1'b0;
            else if (iINSTR_VALID && !w_ready)
                overflow_q <= 1'b1;
        end
    end

`ifdef GPPCU_ISSUE_STATS_EN
    logic [31:0] stat_issued_q;
    logic [31:0] stat_stall_q;

    always_ff @(posedge iACLK or posedge iRST) begin
        if (iRST) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else if (iFLUSH) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (state_q == ISSUE)
                stat_issued_q <= stat_issued_q + 32'd1;
            if (state_q == WAIT && iCORE_BUSY)
                stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign oSTAT_ISSUED = stat_issued_q;
    assign oSTAT_STALL  = stat_stall_q;
`endif

    assign oINSTR_READY = w_ready;
    assign oISSUE_VALID = (state_q == ISSUE);
    assign oISSUE_INSTR = issue_instr_q;
    assign oOVERFLOW    = overflow_q;
    assign oIDLE        = (state_q == IDLE) && w_empty && !iCORE_BUSY;

endmodule : gppcu_instr_issue_ctrl
`default_nettype wire

// File: tb/tb_gppcu_instr_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gppcu_instr_issue_ctrl
// Description : Self-checking bench for gppcu_instr_issue_ctrl. Directed
//               scenarios plus a randomized stream checked against a queue
//               based reference model (occupancy = accepted - issued).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gppcu_instr_issue_ctrl;

    localparam int DL    = 4;
    localparam int W     = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          iINSTR_VALID = 1'b0;
    logic [W-1:0]  iINSTR = '0;
    logic          iRUN = 1'b0;
    logic          iFLUSH = 1'b0;
    logic          iCORE_BUSY = 1'b0;
    logic          oINSTR_READY;
    logic [DL:0]   oQ_COUNT;
    logic          oISSUE_VALID;
    logic [W-1:0]  oISSUE_INSTR;
    logic          oOVERFLOW;
    logic          oIDLE;
`ifdef GPPCU_ISSUE_STATS_EN
    logic [31:0]   oSTAT_ISSUED;
    logic [31:0]   oSTAT_STALL;
`endif

    gppcu_instr_issue_ctrl #(.DEPTH_LOG2(DL), .INSTR_W(W)) dut (
        .iACLK        (clk),
        .iRST         (rst),
        .iINSTR_VALID (iINSTR_VALID),
        .iINSTR       (iINSTR),
        .oINSTR_READY (oINSTR_READY),
        .oQ_COUNT     (oQ_COUNT),
        .iRUN         (iRUN),
        .iFLUSH       (iFLUSH),
        .oISSUE_VALID (oISSUE_VALID),
        .oISSUE_INSTR (oISSUE_INSTR),
        .iCORE_BUSY   (iCORE_BUSY),
`ifdef GPPCU_ISSUE_STATS_EN
        .oSTAT_ISSUED (oSTAT_ISSUED),
        .oSTAT_STALL  (oSTAT_STALL),
`endif
        .oOVERFLOW    (oOVERFLOW),
        .oIDLE        (oIDLE)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every issue strobe seen, with the cycle it appeared in.
    logic [W-1:0] obs_w[$];
    int           obs_c[$];
    always @(negedge clk) begin
        if (!rst && oISSUE_VALID) begin
            obs_w.push_back(oISSUE_INSTR);
            obs_c.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        iINSTR_VALID = 1'b0;
        iINSTR = '0;
        iRUN = 1'b0;
        iFLUSH = 1'b0;
        iCORE_BUSY = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (oINSTR_READY !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", oINSTR_READY); end
        total++; if (oQ_COUNT !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", oQ_COUNT); end
        total++; if (oISSUE_VALID !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", oISSUE_VALID); end
        total++; if (oISSUE_INSTR !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", oISSUE_INSTR); end
        total++; if (oOVERFLOW !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", oOVERFLOW); end
        total++; if (oIDLE !== 1'b1) begin bad++; $display("FAIL rst_idle got=%b exp=1", oIDLE); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_issue();
        do_reset();
        iRUN = 1'b1;
        iINSTR_VALID = 1'b1;
        iINSTR = 32'hA5A5_0001;            // cycle N
        tick();                            // N+1
        iINSTR_VALID = 1'b0;
        total++; if (oISSUE_VALID !== 1'b0) begin bad++; $display("FAIL single_n1_valid got=%b exp=0", oISSUE_VALID); end
        total++; if (oQ_COUNT !== 5'd1) begin bad++; $display("FAIL single_n1_count got=%0d exp=1", oQ_COUNT); end
        tick();                            // N+2
        total++; if (oISSUE_VALID !== 1'b1) begin bad++; $display("FAIL single_n2_valid got=%b exp=1", oISSUE_VALID); end
        total++; if (oISSUE_INSTR !== 32'hA5A5_0001) begin bad++; $display("FAIL single_n2_instr got=%h exp=a5a50001", oISSUE_INSTR); end
        tick();                            // N+3
        total++; if (oISSUE_VALID !== 1'b0) begin bad++; $display("FAIL single_n3_valid got=%b exp=0", oISSUE_VALID); end
        total++; if (oIDLE !== 1'b0) begin bad++; $display("FAIL single_n3_idle got=%b exp=0", oIDLE); end
        tick();                            // N+4
        total++; if (oIDLE !== 1'b1) begin bad++; $display("FAIL single_n4_idle got=%b exp=1", oIDLE); end
        total++; if (oISSUE_INSTR !== 32'hA5A5_0001) begin bad++; $display("FAIL single_hold_instr got=%h exp=a5a50001", oISSUE_INSTR); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w[3];
        int base;
        do_reset();
        base = obs_w.size();
        iRUN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w[i] = $urandom;
            iINSTR_VALID = 1'b1;
            iINSTR = w[i];
            tick();
        end
        iINSTR_VALID = 1'b0;
        // First issue was in the previous cycle; core is busy for 5 cycles.
        iCORE_BUSY = 1'b1;
        repeat (5) tick();
        iCORE_BUSY = 1'b0;
        repeat (10) tick();
        total++; if (obs_w.size() - base !== 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", obs_w.size() - base); end
        if (obs_w.size() - base >= 3) begin
            for (int i = 0; i < 3; i++) begin
                total++; if (obs_w[base+i] !== w[i]) begin bad++; $display("FAIL b2b_word%0d got=%h exp=%h", i, obs_w[base+i], w[i]); end
            end
            total++; if (obs_c[base+1] - obs_c[base] !== 7) begin bad++; $display("FAIL b2b_gap1 got=%0d exp=7", obs_c[base+1] - obs_c[base]); end
            total++; if (obs_c[base+2] - obs_c[base+1] !== 2) begin bad++; $display("FAIL b2b_gap2 got=%0d exp=2", obs_c[base+2] - obs_c[base+1]); end
        end
    endtask

    task automatic test_full_overflow();
        logic [W-1:0] w[17];
        int base;
        do_reset();
        base = obs_w.size();
        iRUN = 1'b0;
        for (int i = 0; i < 17; i++) begin
            w[i] = $urandom;
            iINSTR_VALID = 1'b1;
            iINSTR = w[i];
            tick();
            if (i == 14) begin
                total++; if (oINSTR_READY !== 1'b1) begin bad++; $display("FAIL full15_ready got=%b exp=1", oINSTR_READY); end
            end
            if (i == 15) begin
                total++; if (oINSTR_READY !== 1'b0) begin bad++; $display("FAIL full16_ready got=%b exp=0", oINSTR_READY); end
                total++; if (oOVERFLOW !== 1'b0) begin bad++; $display("FAIL full16_ovf got=%b exp=0", oOVERFLOW); end
            end
        end
        iINSTR_VALID = 1'b0;
        total++; if (oQ_COUNT !== 5'd16) begin bad++; $display("FAIL full_count got=%0d exp=16", oQ_COUNT); end
        total++; if (oINSTR_READY !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", oINSTR_READY); end
        total++; if (oOVERFLOW !== 1'b1) begin bad++; $display("FAIL full_ovf got=%b exp=1", oOVERFLOW); end
        // Drain: exactly the first 16 words come out.
        iRUN = 1'b1;
        repeat (45) tick();
        iRUN = 1'b0;
        tick();
        total++; if (obs_w.size() - base !== 16) begin bad++; $display("FAIL drain_count got=%0d exp=16", obs_w.size() - base); end
        if (obs_w.size() - base >= 16) begin
            for (int i = 0; i < 16; i++) begin
                total++; if (obs_w[base+i] !== w[i]) begin bad++; $display("FAIL drain_word%0d got=%h exp=%h", i, obs_w[base+i], w[i]); end
            end
        end
        total++; if (oOVERFLOW !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", oOVERFLOW); end
        // Queue three words, then flush with a simultaneous push.
        for (int i = 0; i < 3; i++) begin
            iINSTR_VALID = 1'b1;
            iINSTR = $urandom;
            tick();
        end
        total++; if (oQ_COUNT !== 5'd3) begin bad++; $display("FAIL preflush_count got=%0d exp=3", oQ_COUNT); end
        iFLUSH = 1'b1;
        tick();
        iFLUSH = 1'b0;
        iINSTR_VALID = 1'b0;
        total++; if (oQ_COUNT !== 5'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", oQ_COUNT); end
        total++; if (oOVERFLOW !== 1'b0) begin bad++; $display("FAIL flush_ovf got=%b exp=0", oOVERFLOW); end
        total++; if (oINSTR_READY !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", oINSTR_READY); end
    endtask

    task automatic test_flush_wait();
        logic [W-1:0] w0;
        int base;
        do_reset();
        base = obs_w.size();
        iRUN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iINSTR_VALID = 1'b1;
            iINSTR = $urandom;
            if (i == 0) w0 = iINSTR;
            if (i == 3) iCORE_BUSY = 1'b1;
            tick();
        end
        iINSTR_VALID = 1'b0;
        tick();
        total++; if (oQ_COUNT !== 5'd3) begin bad++; $display("FAIL fw_count_before got=%0d exp=3", oQ_COUNT); end
        iFLUSH = 1'b1;
        tick();
        iFLUSH = 1'b0;
        total++; if (oQ_COUNT !== 5'd0) begin bad++; $display("FAIL fw_count_after got=%0d exp=0", oQ_COUNT); end
        tick();
        iCORE_BUSY = 1'b0;
        repeat (10) tick();
        total++; if (oIDLE !== 1'b1) begin bad++; $display("FAIL fw_idle got=%b exp=1", oIDLE); end
        total++; if (obs_w.size() - base !== 1) begin bad++; $display("FAIL fw_issues got=%0d exp=1", obs_w.size() - base); end
        total++; if (oISSUE_INSTR !== w0) begin bad++; $display("FAIL fw_instr got=%h exp=%h", oISSUE_INSTR, w0); end
    endtask

    task automatic test_pause_resume();
        logic [W-1:0] w[3];
        int base;
        do_reset();
        base = obs_w.size();
        iRUN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w[i] = $urandom;
            iINSTR_VALID = 1'b1;
            iINSTR = w[i];
            tick();
        end
        iINSTR_VALID = 1'b0;
        iRUN = 1'b0;
        repeat (8) tick();
        total++; if (oQ_COUNT !== 5'd2) begin bad++; $display("FAIL pause_count got=%0d exp=2", oQ_COUNT); end
        total++; if (obs_w.size() - base !== 1) begin bad++; $display("FAIL pause_issues got=%0d exp=1", obs_w.size() - base); end
        total++; if (oIDLE !== 1'b0) begin bad++; $display("FAIL pause_idle got=%b exp=0", oIDLE); end
        total++; if (oISSUE_INSTR !== w[0]) begin bad++; $display("FAIL pause_hold got=%h exp=%h", oISSUE_INSTR, w[0]); end
        iRUN = 1'b1;
        repeat (10) tick();
        total++; if (obs_w.size() - base !== 3) begin bad++; $display("FAIL resume_issues got=%0d exp=3", obs_w.size() - base); end
        if (obs_w.size() - base >= 3) begin
            for (int i = 0; i < 3; i++) begin
                total++; if (obs_w[base+i] !== w[i]) begin bad++; $display("FAIL resume_word%0d got=%h exp=%h", i, obs_w[base+i], w[i]); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] w[40];
        int base, pushed, acc, iss, occ, busy_left, budget;
        do_reset();
        base = obs_w.size();
        for (int i = 0; i < 40; i++) w[i] = $urandom;
        pushed = 0; acc = 0; iss = 0; busy_left = 0; budget = 0;
        iRUN = 1'b1;
        while (iss < 40 && budget < 3000) begin
            if (oISSUE_VALID) begin
                iss++;
                busy_left = $urandom_range(0, 4);
            end
            occ = acc - iss;
            total++; if (oQ_COUNT !== occ[DL:0]) begin bad++; $display("FAIL wrap_count cyc=%0d got=%0d exp=%0d", cyc, oQ_COUNT, occ); end
            total++; if (oINSTR_READY !== (occ < DEPTH)) begin bad++; $display("FAIL wrap_ready cyc=%0d got=%b exp=%b", cyc, oINSTR_READY, occ < DEPTH); end
            iCORE_BUSY = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            if (pushed < 40 && occ < DEPTH && ($urandom % 4) != 0) begin
                iINSTR_VALID = 1'b1;
                iINSTR = w[pushed];
                pushed++;
                acc++;
            end else begin
                iINSTR_VALID = 1'b0;
            end
            budget++;
            tick();
        end
        iINSTR_VALID = 1'b0;
        iCORE_BUSY = 1'b0;
        total++; if (iss !== 40) begin bad++; $display("FAIL wrap_timeout issued=%0d exp=40", iss); end
        repeat (4) tick();
        total++; if (obs_w.size() - base !== 40) begin bad++; $display("FAIL wrap_issues got=%0d exp=40", obs_w.size() - base); end
        if (obs_w.size() - base >= 40) begin
            for (int i = 0; i < 40; i++) begin
                total++; if (obs_w[base+i] !== w[i]) begin bad++; $display("FAIL wrap_word%0d got=%h exp=%h", i, obs_w[base+i], w[i]); end
            end
        end
        total++; if (oIDLE !== 1'b1) begin bad++; $display("FAIL wrap_idle got=%b exp=1", oIDLE); end
`ifdef GPPCU_ISSUE_STATS_EN
        total++; if (oSTAT_ISSUED !== 32'd40) begin bad++; $display("FAIL stat_issued got=%0d exp=40", oSTAT_ISSUED); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        iRUN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iINSTR_VALID = 1'b1;
            iINSTR = $urandom | 32'h1;
            tick();
        end
        iINSTR_VALID = 1'b0;
        iCORE_BUSY = 1'b1;
        tick();
        #2;
        rst = 1'b1;                        // asynchronous, mid-cycle
        #1;
        total++; if (oQ_COUNT !== 5'd0) begin bad++; $display("FAIL amid_count got=%0d exp=0", oQ_COUNT); end
        total++; if (oISSUE_INSTR !== 32'h0) begin bad++; $display("FAIL amid_instr got=%h exp=0", oISSUE_INSTR); end
        total++; if (oISSUE_VALID !== 1'b0) begin bad++; $display("FAIL amid_valid got=%b exp=0", oISSUE_VALID); end
        total++; if (oINSTR_READY !== 1'b1) begin bad++; $display("FAIL amid_ready got=%b exp=1", oINSTR_READY); end
        iCORE_BUSY = 1'b0;
        iRUN = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_back_to_back();
        test_full_overflow();
        test_flush_wait();
        test_pause_resume();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gppcu_instr_issue_ctrl
`default_nettype wire
